// File: rtl/sccb_cfg_seq_pkg.sv
// Shared definitions for the SCCB configuration sequencer: FSM states, ROM entry
// layout helpers and the R/W bit constants used by the SCCB master.
package sccb_cfg_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_WRITE  = 4'd3,
    ST_WAIT_W = 4'd4,
    ST_READ   = 4'd5,
    ST_WAIT_R = 4'd6,
    ST_DELAY  = 4'd7,
    ST_RETRY  = 4'd8,
    ST_NEXT   = 4'd9,
    ST_DONE   = 4'd10,
    ST_ERROR  = 4'd11
  } state_t;

  localparam int ENTRY_W      = 17;
  localparam int NOVERIFY_BIT = 16;
  localparam int SUB_LSB      = 8;

  localparam logic [7:0] RW_WRITE_MASK = 8'hFE;
  localparam logic [7:0] RW_READ_BIT   = 8'h01;

  function automatic logic [7:0] entry_sub(input logic [ENTRY_W-1:0] e);
    return e[SUB_LSB +: 8];
  endfunction

  function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
    return e[7:0];
  endfunction

  function automatic logic entry_noverify(input logic [ENTRY_W-1:0] e);
    return e[NOVERIFY_BIT];
  endfunction

endpackage

// File: rtl/sccb_cfg_seq_rom.sv
// Synchronous-read command table; contents come from the ROM_INIT image,
// entry i stored at bits [i*17 +: 17].
module sccb_cfg_seq_rom
  import sccb_cfg_seq_pkg::*;
#(
  parameter int NUM_CMDS = 64,
  parameter int AW       = $clog2(NUM_CMDS),
  parameter logic [NUM_CMDS*ENTRY_W-1:0] ROM_INIT = '0
) (
  input  logic               clk,
  input  logic [AW-1:0]      addr,
  output logic [ENTRY_W-1:0] data
);

  logic [ENTRY_W-1:0] rom_mem [NUM_CMDS];

  for (genvar i = 0; i < NUM_CMDS; i++) begin : g_rom
    assign rom_mem[i] = ROM_INIT[i*ENTRY_W +: ENTRY_W];
  end

  // one-cycle read latency
  always_ff @(posedge clk) begin
    data <= rom_mem[addr];
  end

endmodule

// File: rtl/sccb_cfg_seq.sv
// Table-driven SCCB register initialiser: walks the command ROM, issues writes,
// timed delays and optional read-back verification with bounded retries.
module sccb_cfg_seq
  import sccb_cfg_seq_pkg::*;
#(
  parameter logic [7:0]  CHIP_ADDR   = 8'h42,
  parameter int          NUM_CMDS    = 64,
  parameter int          AW          = $clog2(NUM_CMDS),
  parameter logic [7:0]  DELAY_TOKEN = 8'hF0,
  parameter logic [7:0]  END_TOKEN   = 8'hFF,
  parameter int unsigned DELAY_UNIT  = 1000,
  parameter bit          VERIFY      = 1'b1,
  parameter int          MAX_RETRY   = 3,
  parameter logic [NUM_CMDS*ENTRY_W-1:0] ROM_INIT = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_index,
  output logic [AW-1:0] cmd_index,
  output logic          m_start,
  output logic [7:0]    m_addr,
  output logic [7:0]    m_subaddr,
  output logic [7:0]    m_wdata,
  input  logic [7:0]    m_rdata,
  input  logic          m_done,
  input  logic          m_nack
);

  // sized so the largest request (255 units) loads without wrapping
  localparam int DLY_W = $clog2(32'd255 * DELAY_UNIT + 32'd1);

  state_t             state;
  logic [ENTRY_W-1:0] rom_data;
  logic [7:0]         sub_r;
  logic [7:0]         data_r;
  logic               noverify_r;
  logic [3:0]         retry_r;
  logic [DLY_W-1:0]   dly_cnt_r;

  sccb_cfg_seq_rom #(
    .NUM_CMDS (NUM_CMDS),
    .AW       (AW),
    .ROM_INIT (ROM_INIT)
  ) u_rom (
    .clk  (clk),
    .addr (cmd_index),
    .data (rom_data)
  );

  // sequencer FSM, counters and registered bus request outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_index  <= '0;
      cmd_index  <= '0;
      m_start    <= 1'b0;
      m_addr     <= 8'h00;
      m_subaddr  <= 8'h00;
      m_wdata    <= 8'h00;
      sub_r      <= 8'h00;
      data_r     <= 8'h00;
      noverify_r <= 1'b0;
      retry_r    <= 4'd0;
      dly_cnt_r  <= '0;
    end else begin
      m_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            cmd_index <= '0;
            retry_r   <= 4'd0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          sub_r      <= entry_sub(rom_data);
          data_r     <= entry_data(rom_data);
          noverify_r <= entry_noverify(rom_data);
          if (entry_sub(rom_data) == END_TOKEN) begin
            state <= ST_DONE;
          end else if (entry_sub(rom_data) == DELAY_TOKEN) begin
            // a zero count skips the delay state entirely
            if (entry_data(rom_data) == 8'd0) begin
              state <= ST_NEXT;
            end else begin
              dly_cnt_r <= DLY_W'(32'(entry_data(rom_data)) * DELAY_UNIT - 32'd1);
              state     <= ST_DELAY;
            end
          end else begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          m_addr    <= CHIP_ADDR & RW_WRITE_MASK;
          m_subaddr <= sub_r;
          m_wdata   <= data_r;
          m_start   <= 1'b1;
          state     <= ST_WAIT_W;
        end
        ST_WAIT_W: begin
          if (m_done) begin
            if (m_nack)                   state <= ST_RETRY;
            else if (VERIFY && !noverify_r) state <= ST_READ;
            else                          state <= ST_NEXT;
          end
        end
        ST_READ: begin
          m_addr    <= CHIP_ADDR | RW_READ_BIT;
          m_subaddr <= sub_r;
          m_start   <= 1'b1;
          state     <= ST_WAIT_R;
        end
        ST_WAIT_R: begin
          if (m_done) begin
            if (m_nack || (m_rdata != data_r)) state <= ST_RETRY;
            else                               state <= ST_NEXT;
          end
        end
        ST_DELAY: begin
          if (dly_cnt_r == '0) state <= ST_NEXT;
          else                 dly_cnt_r <= dly_cnt_r - DLY_W'(1);
        end
        ST_RETRY: begin
          if (retry_r < 4'(MAX_RETRY)) begin
            retry_r <= retry_r + 4'd1;
            state   <= ST_WRITE;
          end else begin
            err_index <= cmd_index;
            state     <= ST_ERROR;
          end
        end
        ST_NEXT: begin
          retry_r <= 4'd0;
          if (cmd_index == AW'(NUM_CMDS - 1)) begin
            state <= ST_DONE;
          end else begin
            cmd_index <= cmd_index + AW'(1);
            state     <= ST_FETCH;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_ERROR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
